sim_finish_ctrl: RTL
====================

SIM_FINISH_CTRL -- requirements
Module: sim_finish_ctrl

Interface
REQ-001 SHALL have parameter DrainCycles, default 7, meaning cycles spent in DRAIN before DONE (legal range 1..255).
REQ-002 SHALL have parameter PassCode, default 32'hDEADBEEF, meaning the status word that signals test pass.
REQ-003 SHALL have parameter FailCode, default 32'hBAADF00D, meaning the status word that signals test fail.
REQ-004 SHALL have parameter TimeoutCycles, default 32'd100_000_000, meaning the RUN-state cycle limit before forced end.
REQ-005 SHALL have port clk_sys  input  1  system clock.
REQ-006 SHALL have port rst_sys_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port status_i  input  32  software status word (GPIO output pins).
REQ-008 SHALL have port end_pulse_o  output  1  one-cycle pulse on the RUN->DRAIN transition (bench $display hook).
REQ-009 SHALL have port done_o  output  1  high in DONE; bench calls $finish.
REQ-010 SHALL have port pass_o  output  1  end cause was PassCode.
REQ-011 SHALL have port fail_o  output  1  end cause was FailCode.
REQ-012 SHALL have port timeout_o  output  1  end cause was timeout.
REQ-013 SHALL have port state_o  output  2  current FSM state: RUN=0, DRAIN=1, DONE=2.
REQ-014 SHALL have port cycle_count_o  output  32  cycles elapsed in RUN since reset, saturating.
REQ-015 SHALL have port end_code_o  output  32  status_i captured on the RUN->DRAIN transition (0 on timeout).

Function
REQ-016 SHALL implement FSM RUN -> DRAIN -> DONE; DONE is terminal until reset; encoding 3 is unreachable and SHALL return to RUN.
REQ-017 SHALL, in RUN, compare status_i combinationally each cycle against FailCode, PassCode and timeout; a match moves to DRAIN on the next clk_sys edge.
REQ-018 SHALL resolve simultaneous causes with priority fail > pass > timeout; exactly one of pass_o/fail_o/timeout_o is set.
REQ-019 SHALL register the cause flags and end_code_o on the RUN->DRAIN edge and hold them until reset.
REQ-020 SHALL assert end_pulse_o for exactly the first cycle in DRAIN.
REQ-021 SHALL clear an 8-bit drain counter on DRAIN entry, increment it each DRAIN cycle, and move to DONE on the cycle after the counter equals DrainCycles-1 (DRAIN lasts exactly DrainCycles cycles).
REQ-022 SHALL ignore status_i in DRAIN and DONE; later code writes do not change cause or end_code_o.
REQ-023 SHALL increment cycle_count_o by 1 each RUN cycle, saturate at 32'hFFFFFFFF, and freeze on leaving RUN.
REQ-024 SHALL treat timeout as cycle_count_o == TimeoutCycles-1 in RUN (timeout entry after exactly TimeoutCycles RUN cycles).
REQ-025 SHALL drive done_o high in every DONE cycle.
REQ-026 SHALL flag an elaboration error when DrainCycles is 0 or above 255, or PassCode equals FailCode.

Reset
REQ-027 SHALL, with rst_sys_n low, force state RUN and all outputs 0 (end_pulse_o, done_o, pass_o, fail_o, timeout_o, state_o, cycle_count_o, end_code_o) asynchronously.
REQ-028 SHALL, on reset asserted mid-DRAIN or in DONE, abandon the test end and restart in RUN with counters cleared.
REQ-029 SHALL not evaluate status_i in the first cycle after reset release unless clk_sys has sampled rst_sys_n high.

Configuration
REQ-030 SHALL implement timeout detection only when macro SIM_FINISH_TIMEOUT_EN is defined.
REQ-031 SHALL, without SIM_FINISH_TIMEOUT_EN, tie timeout_o to 0, never take the timeout transition, and keep cycle_count_o counting.

Verification
REQ-032 SHALL cover: status_i=32'hDEADBEEF at RUN cycle 100 -> end_pulse_o at cycle 101, pass_o=1, end_code_o=32'hDEADBEEF, done_o from cycle 108 (DrainCycles=7).
REQ-033 SHALL cover: status_i=32'hBAADF00D, then 32'hDEADBEEF during DRAIN -> fail_o=1, pass_o=0, end_code_o=32'hBAADF00D.
REQ-034 SHALL cover: TimeoutCycles=50, SIM_FINISH_TIMEOUT_EN defined, status_i=0 -> DRAIN after 50 RUN cycles, timeout_o=1, end_code_o=0, cycle_count_o=50; macro undefined -> stays RUN past 1000 cycles.
REQ-035 SHALL cover: TimeoutCycles=50, FailCode presented on RUN cycle 50 (timeout cycle) -> fail_o=1, timeout_o=0.
REQ-036 SHALL cover: rst_sys_n pulsed low at DRAIN cycle 3 -> all outputs 0 immediately; subsequent PassCode produces a full 7-cycle DRAIN then done_o.
REQ-037 SHALL cover: DrainCycles=1 with PassCode -> end_pulse_o and DRAIN for one cycle, done_o on the next cycle.

Source files
------------

// File: rtl/sim_finish_ctrl.sv
// Simulation end controller: watches a software status word, latches the end cause, drains, then signals DONE.
// Timeout detection is compiled in only when `SIM_FINISH_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module sim_finish_ctrl #(
  parameter int unsigned DrainCycles   = 7,
  parameter logic [31:0] PassCode      = 32'hDEADBEEF,
  parameter logic [31:0] FailCode      = 32'hBAADF00D,
  parameter logic [31:0] TimeoutCycles = 32'd100_000_000
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic [31:0] status_i,
  output logic        end_pulse_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [1:0]  state_o,
  output logic [31:0] cycle_count_o,
  output logic [31:0] end_code_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2,
    ST_BAD   = 2'd3
  } state_t;

  localparam logic [7:0] DrainLast = 8'(DrainCycles - 1);

  if (DrainCycles == 0 || DrainCycles > 255) begin : g_bad_drain
    $error("sim_finish_ctrl: DrainCycles must be in 1..255");
  end
  if (PassCode == FailCode) begin : g_bad_codes
    $error("sim_finish_ctrl: PassCode and FailCode must differ");
  end
  if (TimeoutCycles == 32'd0) begin : g_bad_timeout
    $error("sim_finish_ctrl: TimeoutCycles must be nonzero");
  end

  state_t      r_state;
  state_t      w_state_next;
  logic        r_armed;
  logic        r_end_pulse;
  logic        r_pass;
  logic        r_fail;
  logic [31:0] r_cycle_count;
  logic [31:0] r_end_code;
  logic [7:0]  r_drain_cnt;
  logic        w_fail_hit;
  logic        w_pass_hit;
  logic        w_timeout_hit;
  logic        w_enter_drain;

  // r_armed keeps status_i out of the decision until a clock edge has seen reset released
  assign w_fail_hit = r_armed && (status_i == FailCode);
  assign w_pass_hit = r_armed && (status_i == PassCode);

`ifdef SIM_FINISH_TIMEOUT_EN
  localparam logic [31:0] TimeoutLast = TimeoutCycles - 32'd1;
  logic r_timeout;

  assign w_timeout_hit = (r_cycle_count == TimeoutLast);

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_timeout <= 1'b0;
    end else if (w_enter_drain) begin
      r_timeout <= ~w_fail_hit & ~w_pass_hit;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign timeout_o     = 1'b0;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_enter_drain = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_fail_hit || w_pass_hit || w_timeout_hit) begin
          w_state_next  = ST_DRAIN;
          w_enter_drain = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == DrainLast) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_DONE;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state       <= ST_RUN;
      r_armed       <= 1'b0;
      r_end_pulse   <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_cycle_count <= 32'd0;
      r_end_code    <= 32'd0;
      r_drain_cnt   <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_armed     <= 1'b1;
      r_end_pulse <= w_enter_drain;

      if (r_state == ST_RUN && r_cycle_count != 32'hFFFF_FFFF) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end

      if (w_enter_drain) begin
        r_drain_cnt <= 8'd0;
      end else if (r_state == ST_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 8'd1;
      end

      // cause and code are captured once; later status writes cannot reach them
      if (w_enter_drain) begin
        r_fail     <= w_fail_hit;
        r_pass     <= w_pass_hit & ~w_fail_hit;
        r_end_code <= (w_fail_hit || w_pass_hit) ? status_i : 32'd0;
      end
    end
  end

  assign end_pulse_o   = r_end_pulse;
  assign done_o        = (r_state == ST_DONE);
  assign pass_o        = r_pass;
  assign fail_o        = r_fail;
  assign state_o       = r_state;
  assign cycle_count_o = r_cycle_count;
  assign end_code_o    = r_end_code;

endmodule
